// File: rtl/frame_streamer_if.sv
// Video streaming handshake between frame_streamer and a sync generator.
// A beat transfers on a rising edge where out_valid and out_ready are both 1.
interface frame_streamer_if;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_empty;

  modport master (output out_valid, out_data, out_sop, out_eop, out_empty, input out_ready);
  modport slave  (input out_valid, out_data, out_sop, out_eop, out_empty, output out_ready);
endinterface

// File: rtl/frame_streamer.sv
// Streams a ROM-stored grey image (optionally scaled x2/x4) into a raster frame,
// filling the area outside the image with a background colour.
module frame_streamer #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          IMG_W      = 256,
  parameter int          IMG_H      = 256,
  parameter int          NUM_IMAGES = 2,
  parameter int          X_OFF      = 0,
  parameter int          Y_OFF      = 0,
  parameter int          ADDR_W     = 19,
  parameter int          PIX_W      = 8,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  localparam int         SEL_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [SEL_W-1:0]  image_sel,
  input  logic [1:0]        scale,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  frame_streamer_if.master  vid,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]       r_state;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [SEL_W-1:0] r_sel;
  logic [1:0]       r_scale;
  logic             r_inside;
  logic             r_done;

  logic             w_xfer, w_last_x, w_last_y, w_eop, w_restart;
  logic [XW-1:0]    w_nx, w_ax;
  logic [YW-1:0]    w_ny, w_ay;
  logic [SEL_W-1:0] w_asel;
  logic [1:0]       w_asc, w_sh;
  logic [31:0]      w_ax32, w_ay32, w_dx, w_dy, w_wspan, w_hspan;
  logic             w_in;
  logic [7:0]       w_chan;

  assign w_xfer    = (r_state == S_STREAM) && vid.out_ready;
  assign w_last_x  = (r_x == XW'(H_ACTIVE - 1));
  assign w_last_y  = (r_y == YW'(V_ACTIVE - 1));
  assign w_eop     = (r_state == S_STREAM) && w_last_x && w_last_y;
  assign w_restart = w_xfer && w_eop && enable;

  always_comb begin
    w_nx = r_x + XW'(1);
    w_ny = r_y;
    if (w_last_x) begin
      w_nx = '0;
      w_ny = w_last_y ? '0 : r_y + YW'(1);
    end
  end

  // The ROM is addressed for the beat that will be on the output next cycle:
  // the following pixel when this beat transfers, otherwise the current one again.
  // Back-to-back frames take the new image/scale here, so no priming bubble is needed.
  always_comb begin
    w_ax   = r_x;
    w_ay   = r_y;
    w_asel = r_sel;
    w_asc  = r_scale;
    if (w_xfer) begin
      w_ax = w_nx;
      w_ay = w_ny;
    end
    if (w_restart) begin
      w_asel = image_sel;
      w_asc  = scale;
    end
  end

  assign w_sh    = (w_asc == 2'd1) ? 2'd1 : (w_asc == 2'd2) ? 2'd2 : 2'd0;
  assign w_ax32  = 32'(w_ax);
  assign w_ay32  = 32'(w_ay);
  assign w_dx    = w_ax32 - 32'(X_OFF);
  assign w_dy    = w_ay32 - 32'(Y_OFF);
  assign w_wspan = 32'(IMG_W) << w_sh;
  assign w_hspan = 32'(IMG_H) << w_sh;
  assign w_in    = (w_ax32 >= 32'(X_OFF)) && (w_ax32 < 32'(X_OFF) + w_wspan) &&
                   (w_ay32 >= 32'(Y_OFF)) && (w_ay32 < 32'(Y_OFF) + w_hspan);

  assign rom_addr = (r_state == S_IDLE) ? '0 :
                    ADDR_W'(32'(w_asel) * 32'(IMG_W * IMG_H) +
                            (w_dy >> w_sh) * 32'(IMG_W) + (w_dx >> w_sh));

  generate
    if (PIX_W >= 8) begin : g_chan_trunc
      assign w_chan = rom_data[PIX_W-1 -: 8];
    end else begin : g_chan_pad
      assign w_chan = {rom_data, {(8 - PIX_W){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_sel    <= '0;
      r_scale  <= 2'd0;
      r_inside <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= w_xfer && w_eop;
      r_inside <= w_in;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_sel   <= image_sel;
            r_scale <= scale;
            r_state <= S_PRIME;
          end
        end
        S_PRIME: r_state <= S_STREAM;
        S_STREAM: begin
          if (w_xfer) begin
            r_x <= w_nx;
            r_y <= w_ny;
            if (w_eop) begin
              if (enable) begin
                r_sel   <= image_sel;
                r_scale <= scale;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vid.out_valid = (r_state == S_STREAM);
  assign vid.out_sop   = (r_state == S_STREAM) && (r_x == '0) && (r_y == '0);
  assign vid.out_eop   = w_eop;
  assign vid.out_empty = 1'b0;
  assign vid.out_data  = (r_state != S_STREAM) ? 24'h0 :
                         r_inside ? {w_chan, w_chan, w_chan} : BG_COLOR;
  assign frame_done    = r_done;
  assign dbg_state     = r_state;
endmodule
